// File: rtl/axis_pkt_pkg.sv
// Shared types and width helpers for the axis_pkt_rx packet receiver.
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DRAIN   = 2'd2,
        OUT     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ID    = 2'd1,
        ERR_SHORT = 2'd2,
        ERR_LONG  = 2'd3
    } err_code_t;

    function automatic int ch_w(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

    function automatic int cnt_w(input int pck_size);
        if (pck_size > 1) begin
            return $clog2(pck_size);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/axis_pkt_stats.sv
// Saturating 16-bit packet and error counters for axis_pkt_rx.
module axis_pkt_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_inc,
    input  logic        err_inc,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    logic [15:0] pkt_cnt_r;
    logic [15:0] err_cnt_r;

    // Count completed handshakes and error pulses, holding at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_r <= 16'd0;
            err_cnt_r <= 16'd0;
        end else begin
            if (pkt_inc && (pkt_cnt_r != 16'hFFFF)) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
            if (err_inc && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI-Stream packet receiver: header ID check, payload assembly, framing errors.
// Define AXIS_PKT_RX_STATS_EN to add the pkt_cnt/err_cnt statistics outputs.
module axis_pkt_rx
    import axis_pkt_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter int         PCK_SIZE = 4,
    parameter int         NUM_CH   = 2,
    parameter logic [7:0] BASE_ID  = 8'h7F
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [DATA_W-1:0]            s_tdata,
    input  logic                         s_tlast,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PCK_SIZE*DATA_W-1:0]   out_data,
    output logic [ch_w(NUM_CH)-1:0]      out_ch,
    output logic                         err_valid,
    output logic [1:0]                   err_code
`ifdef AXIS_PKT_RX_STATS_EN
    ,
    output logic [15:0]                  pkt_cnt,
    output logic [15:0]                  err_cnt
`endif
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = cnt_w(PCK_SIZE);

    state_t                     state_r;
    logic                       s_tready_r;
    logic                       out_valid_r;
    logic [PCK_SIZE*DATA_W-1:0] out_data_r;
    logic [CH_W-1:0]            out_ch_r;
    logic                       err_valid_r;
    err_code_t                  err_code_r;
    logic [CNT_W-1:0]           cnt_r;

    logic                       beat_s;
    logic [8:0]                 id_off_s;
    logic                       id_ok_s;
    logic                       cnt_last_s;

    assign beat_s     = s_tvalid && s_tready_r;
    // Nine-bit difference so IDs below BASE_ID show up as a borrow.
    assign id_off_s   = {1'b0, s_tdata[7:0]} - {1'b0, BASE_ID};
    assign id_ok_s    = !id_off_s[8] && (id_off_s < 9'(NUM_CH));
    assign cnt_last_s = (cnt_r == CNT_W'(PCK_SIZE - 1));

    // Packet framing FSM with registered stream, output and error signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            s_tready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            err_valid_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            cnt_r       <= '0;
        end else begin
            err_valid_r <= 1'b0;
            err_code_r  <= ERR_NONE;
            case (state_r)
                IDLE: begin
                    s_tready_r <= 1'b1;
                    if (beat_s) begin
                        if (!id_ok_s) begin
                            err_valid_r <= 1'b1;
                            err_code_r  <= ERR_ID;
                            if (!s_tlast) begin
                                state_r <= DRAIN;
                            end
                        end else if (s_tlast) begin
                            err_valid_r <= 1'b1;
                            err_code_r  <= ERR_SHORT;
                        end else begin
                            out_ch_r <= id_off_s[CH_W-1:0];
                            cnt_r    <= '0;
                            state_r  <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (beat_s) begin
                        for (int i = 0; i < PCK_SIZE; i++) begin
                            if (cnt_r == CNT_W'(i)) begin
                                out_data_r[i*DATA_W +: DATA_W] <= s_tdata;
                            end
                        end
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_last_s) begin
                            if (s_tlast) begin
                                out_valid_r <= 1'b1;
                                s_tready_r  <= 1'b0;
                                state_r     <= OUT;
                            end else begin
                                err_valid_r <= 1'b1;
                                err_code_r  <= ERR_LONG;
                                state_r     <= DRAIN;
                            end
                        end else if (s_tlast) begin
                            err_valid_r <= 1'b1;
                            err_code_r  <= ERR_SHORT;
                            state_r     <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (beat_s && s_tlast) begin
                        state_r <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        s_tready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    s_tready_r  <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign s_tready  = s_tready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign err_valid = err_valid_r;
    assign err_code  = err_code_r;

`ifdef AXIS_PKT_RX_STATS_EN
    axis_pkt_stats u_stats (
        .clk     (clk),
        .rst     (rst),
        .pkt_inc (out_valid_r && out_ready),
        .err_inc (err_valid_r),
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
    );
`endif

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Directed self-checking bench for axis_pkt_rx with default parameters.
module tb_axis_pkt_rx;

    logic        clk;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [0:0]  out_ch;
    logic        err_valid;
    logic [1:0]  err_code;
`ifdef AXIS_PKT_RX_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
`endif

    int vec_cnt;
    int miss_cnt;
    int out_seen;
    int err_seen;
    logic [31:0] out_q[$];
    logic [0:0]  ch_q[$];

    axis_pkt_rx dut (
        .clk       (clk),
        .rst       (rst),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .err_valid (err_valid),
        .err_code  (err_code)
`ifdef AXIS_PKT_RX_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output handshake and every error pulse.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            out_q.push_back(out_data);
            ch_q.push_back(out_ch);
            out_seen++;
        end
        if (err_valid) begin
            err_seen++;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_tready) break;
            n++;
            if (n > 50) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL beat_timeout data=%h s_tready stuck at %b, need 1", d, s_tready);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({s_tready, out_valid, out_data, out_ch, err_valid, err_code} !== 37'd0) begin
            miss_cnt++;
            $display("FAIL reset_outputs got rdy=%b v=%b d=%h ch=%b ev=%b ec=%0d, need all 0",
                     s_tready, out_valid, out_data, out_ch, err_valid, err_code);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vec_cnt++;
        if (s_tready !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_release_tready got %b need 0", s_tready);
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (s_tready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL first_edge_tready got %b need 1", s_tready);
        end
    endtask

    task automatic test_basic();
        int e0;
        e0 = err_seen;
        send_beat(8'h7F, 1'b0);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b0);
        send_beat(8'hDD, 1'b1);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA || out_ch !== 1'b0) begin
            miss_cnt++;
            $display("FAIL basic_out got v=%b d=%h ch=%b need v=1 d=ddccbbaa ch=0",
                     out_valid, out_data, out_ch);
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || s_tready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL basic_after_hs got v=%b rdy=%b need v=0 rdy=1", out_valid, s_tready);
        end
        vec_cnt++;
        if (err_seen !== e0) begin
            miss_cnt++;
            $display("FAIL basic_no_err got %0d errors need 0", err_seen - e0);
        end
    endtask

    task automatic test_back_to_back();
        int o0;
        o0 = out_seen;
        out_q.delete();
        ch_q.delete();
        send_beat(8'h80, 1'b0);
        send_beat(8'h45, 1'b0);
        send_beat(8'hAA, 1'b0);
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b1);
        send_beat(8'h7F, 1'b0);
        send_beat(8'h43, 1'b0);
        send_beat(8'h21, 1'b0);
        send_beat(8'h44, 1'b0);
        send_beat(8'h55, 1'b1);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_seen - o0 !== 2) begin
            miss_cnt++;
            $display("FAIL b2b_count got %0d outputs need 2", out_seen - o0);
        end else begin
            vec_cnt++;
            if (out_q[0] !== 32'h3412AA45 || ch_q[0] !== 1'b1) begin
                miss_cnt++;
                $display("FAIL b2b_pkt0 got d=%h ch=%b need 3412aa45 ch=1", out_q[0], ch_q[0]);
            end
            vec_cnt++;
            if (out_q[1] !== 32'h55442143 || ch_q[1] !== 1'b0) begin
                miss_cnt++;
                $display("FAIL b2b_pkt1 got d=%h ch=%b need 55442143 ch=0", out_q[1], ch_q[1]);
            end
        end
    endtask

    task automatic test_bad_id();
        int o0;
        int e0;
        o0 = out_seen;
        send_beat(8'h00, 1'b0);
        vec_cnt++;
        if (err_valid !== 1'b1 || err_code !== 2'd1) begin
            miss_cnt++;
            $display("FAIL bad_id_err got ev=%b ec=%0d need ev=1 ec=1", err_valid, err_code);
        end
        e0 = err_seen + 1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b1);
        vec_cnt++;
        if (err_valid !== 1'b0 || out_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL bad_id_drain got ev=%b v=%b need 0 0", err_valid, out_valid);
        end
        out_q.delete();
        send_beat(8'h7F, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b1);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_seen - o0 !== 1 || err_seen !== e0) begin
            miss_cnt++;
            $display("FAIL bad_id_counts got outs=%0d errs=%0d need 1 and %0d",
                     out_seen - o0, err_seen, e0);
        end else begin
            vec_cnt++;
            if (out_q[0] !== 32'h04030201) begin
                miss_cnt++;
                $display("FAIL bad_id_recover got %h need 04030201", out_q[0]);
            end
        end
    endtask

    task automatic test_short_long();
        int o0;
        int e0;
        o0 = out_seen;
        e0 = err_seen;
        send_beat(8'h7F, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        vec_cnt++;
        if (err_valid !== 1'b1 || err_code !== 2'd2) begin
            miss_cnt++;
            $display("FAIL short_err got ev=%b ec=%0d need ev=1 ec=2", err_valid, err_code);
        end
        send_beat(8'h7F, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        vec_cnt++;
        if (err_valid !== 1'b1 || err_code !== 2'd3) begin
            miss_cnt++;
            $display("FAIL long_err got ev=%b ec=%0d need ev=1 ec=3", err_valid, err_code);
        end
        send_beat(8'h55, 1'b1);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_seen !== o0 || err_seen - e0 !== 2 || err_code !== 2'd0) begin
            miss_cnt++;
            $display("FAIL short_long_counts got outs=%0d errs=%0d ec=%0d need 0 2 0",
                     out_seen - o0, err_seen - e0, err_code);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        send_beat(8'h80, 1'b0);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (s_tready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h04030201 || out_ch !== 1'b1) begin
                miss_cnt++;
                bad++;
                if (bad < 4) begin
                    $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b d=%h ch=%b need 0 1 04030201 1",
                             i, s_tready, out_valid, out_data, out_ch);
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || s_tready !== 1'b1 || out_data !== 32'h04030201) begin
            miss_cnt++;
            $display("FAIL stall_release got v=%b rdy=%b d=%h need 0 1 04030201",
                     out_valid, s_tready, out_data);
        end
    endtask

    task automatic test_stats();
`ifdef AXIS_PKT_RX_STATS_EN
        vec_cnt++;
        if (pkt_cnt !== 16'd5 || err_cnt !== 16'd3) begin
            miss_cnt++;
            $display("FAIL stats_counts got pkt=%0d err=%0d need 5 3", pkt_cnt, err_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int o0;
        send_beat(8'h7F, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({s_tready, out_valid, out_data, out_ch, err_valid, err_code} !== 37'd0) begin
            miss_cnt++;
            $display("FAIL mid_reset got rdy=%b v=%b d=%h ch=%b ev=%b ec=%0d need all 0",
                     s_tready, out_valid, out_data, out_ch, err_valid, err_code);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        o0 = out_seen;
        out_q.delete();
        ch_q.delete();
        send_beat(8'h80, 1'b0);
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0B, 1'b0);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h0D, 1'b1);
        @(posedge clk);
        #1;
        vec_cnt++;
        if (out_seen - o0 !== 1) begin
            miss_cnt++;
            $display("FAIL post_reset_count got %0d outputs need 1", out_seen - o0);
        end else begin
            vec_cnt++;
            if (out_q[0] !== 32'h0D0C0B0A || ch_q[0] !== 1'b1) begin
                miss_cnt++;
                $display("FAIL post_reset_pkt got d=%h ch=%b need 0d0c0b0a ch=1", out_q[0], ch_q[0]);
            end
        end
`ifdef AXIS_PKT_RX_STATS_EN
        vec_cnt++;
        if (pkt_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            miss_cnt++;
            $display("FAIL post_reset_stats got pkt=%0d err=%0d need 1 0", pkt_cnt, err_cnt);
        end
`endif
    endtask

    initial begin
        vec_cnt   = 0;
        miss_cnt  = 0;
        out_seen  = 0;
        err_seen  = 0;
        rst       = 1'b1;
        s_tvalid  = 1'b0;
        s_tdata   = 8'h00;
        s_tlast   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_id();
        test_short_long();
        test_backpressure();
        test_stats();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/axis_pkt_rx.md
Name: axis_pkt_rx

Overview:
Parametrised AXI-Stream packet receiver, successor to the fixed 8-bit single-ID stream slave. Each packet is one header beat carrying a channel ID, then PCK_SIZE payload beats, with tlast on the final beat. The block checks ID and framing, assembles the payload into one wide word and presents it on a valid/ready output port with the decoded channel number. It provides backpressure through s_tready and reports framing errors. It feeds the measurement/control logic downstream.

Parameters:
DATA_W, 8, tdata width in bits; must be >= 8 (ID read from tdata[7:0])
PCK_SIZE, 4, payload beats per packet; must be >= 1
NUM_CH, 2, number of accepted channel IDs
BASE_ID, 8'h7F, ID of channel 0; channel k has ID BASE_ID+k; BASE_ID+NUM_CH-1 must be <= 8'hFF

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
s_tvalid  in  1  stream beat valid
s_tready  out  1  stream beat ready
s_tdata  in  DATA_W  header ID or payload beat
s_tlast  in  1  last beat of packet
out_valid  out  1  assembled packet valid
out_ready  in  1  downstream accepts packet
out_data  out  PCK_SIZE*DATA_W  payload; beat i at [i*DATA_W +: DATA_W]
out_ch  out  CH_W=max(1,$clog2(NUM_CH))  channel index (ID-BASE_ID)
err_valid  out  1  one-cycle error pulse
err_code  out  2  0 none, 1 ERR_ID, 2 ERR_SHORT, 3 ERR_LONG

Behaviour:
- Beat accepted when s_tvalid && s_tready at a rising clk edge.
- Reset (async assert, sync release): state IDLE, s_tready=0, out_valid=0, out_data=0, out_ch=0, err_valid=0, err_code=0, beat counter=0. s_tready becomes 1 on the first clk edge after rst deasserts.
- FSM states: IDLE, PAYLOAD, DRAIN, OUT. s_tready=1 in IDLE, PAYLOAD and DRAIN; s_tready=0 in OUT.
- IDLE, header accepted:
  - ID in range, tlast=0 -> latch out_ch; counter=0; go to PAYLOAD.
  - ID in range, tlast=1 -> ERR_SHORT; stay in IDLE.
  - ID out of range -> ERR_ID; go to DRAIN if tlast=0, stay in IDLE if tlast=1.
- PAYLOAD, beat accepted:
  - Store the beat at index counter, then counter++.
  - tlast with counter<PCK_SIZE-1 -> ERR_SHORT; discard; go to IDLE.
  - counter==PCK_SIZE-1 without tlast -> ERR_LONG; discard; go to DRAIN.
  - counter==PCK_SIZE-1 with tlast -> go to OUT.
- DRAIN: accept and discard beats until a tlast beat, then go to IDLE. No further error is reported for the drained beats.
- OUT: out_valid=1; out_data and out_ch held stable. On out_valid && out_ready -> out_valid=0 and go to IDLE in the same edge.
- Latency: out_valid rises on the edge that accepts the final payload beat, i.e. it is visible the cycle after. Minimum packet period is PCK_SIZE+2 cycles when out_ready is held at 1.
- err_valid and err_code are registered and asserted for exactly one cycle on the edge that accepts the offending beat. Otherwise err_code=0.
- s_tvalid low mid-packet: state and counter are held; no timeout.
- out_data holds its last value after the handshake. Payload beats are not cleared between packets.
- Reset mid-packet or mid-OUT: the partial or pending packet is lost and no error is reported.

Optional Feature:
AXIS_PKT_RX_STATS_EN
- Defined: adds outputs pkt_cnt[15:0] and err_cnt[15:0], both reset to 0. pkt_cnt increments on each out handshake. err_cnt increments on each err_valid pulse. Both saturate at 16'hFFFF.
- Undefined: these ports and the counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package axis_pkt_pkg holds:
  - state enum state_t {IDLE, PAYLOAD, DRAIN, OUT};
  - err_code_t enum (2-bit, values above);
  - localparam function for CH_W.
- One sub-module, axis_pkt_stats: two saturating 16-bit counters, instantiated only under the macro.
- The rest is a single FSM plus the payload register.

Test Plan:
- Defaults, out_ready=1; send 7F, AA BB CC DD(tlast) -> out_valid one cycle, out_data=32'hDDCCBBAA, out_ch=0, no error.
- Send 80, 45 AA 12 34(tlast), then immediately 7F, 43 21 44 55(tlast) -> two outputs 32'h3412AA45 ch1 and 32'h55442143 ch0, no beats lost.
- Send 00, 11 22 33 44(tlast) -> err_code=1 pulse on header; beats drained; no out_valid; next valid packet received normally.
- Send 7F, 11 22(tlast) -> ERR_SHORT pulse on beat 22; then 7F, 11 22 33 44 55(tlast) -> ERR_LONG on beat 44; 55 drained; no output from either.
- out_ready=0 after a good packet -> s_tready=0 and out_data stable for 20 cycles; out_ready=1 -> handshake, then s_tready=1.
- Assert rst for 1 cycle after 2 payload beats -> all outputs return to reset values; a following good packet is received correctly. With the macro defined, pkt_cnt and err_cnt match the counts from the scenarios above.
